// File: rtl/uart_hex_byte_sender.sv
// uart_hex_byte_sender: sends a captured byte as two ASCII hex digits plus CR LF over 8N1 UART
module uart_hex_byte_sender #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       send,
  output logic       uart_txd,
  output logic       busy,
  output logic       done
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [1:0] chr_q, chr_d;
  logic [7:0] byte_q, byte_d;
  logic txd_q, txd_d, busy_q, busy_d, done_q, done_d;
  logic [7:0] char_w;
  logic bit_end;
  function automatic logic [7:0] hex(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'd0, n} : 8'h37 + {4'd0, n};
  endfunction
  assign char_w = chr_q == 2'd0 ? hex(byte_q[7:4]) :
                  chr_q == 2'd1 ? hex(byte_q[3:0]) :
                  chr_q == 2'd2 ? 8'h0D : 8'h0A;
  assign bit_end = baud_q == BAUD_LAST;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      chr_q   <= '0;
      byte_q  <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      chr_q   <= chr_d;
      byte_q  <= byte_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  // Bit and character indices wrap to 0 on their final increment, so IDLE always sees them cleared.
  always_comb begin
    state_d = state_q;
    baud_d  = (state_q == IDLE || bit_end) ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    chr_d   = chr_q;
    byte_d  = byte_q;
    case (state_q)
      IDLE: if (send) begin
        state_d = START;
        byte_d  = data_in;
      end
      START: if (bit_end) state_d = DATA;
      DATA: if (bit_end) begin
        bit_d   = bit_q + 3'd1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (bit_end) begin
        chr_d   = chr_q + 2'd1;
        state_d = chr_q == 2'd3 ? IDLE : START;
      end
    endcase
  end
  // Outputs are registered from the next state so the line changes on the same edge as the FSM.
  always_comb begin
    txd_d  = state_d == START ? 1'b0 : state_d == DATA ? char_w[bit_d] : 1'b1;
    busy_d = state_d != IDLE;
    done_d = state_q == STOP && state_d == IDLE;
  end
  assign uart_txd = txd_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_uart_hex_byte_sender.sv
// tb_uart_hex_byte_sender: directed vector bench for the hex byte UART sender
module tb_uart_hex_byte_sender;
  localparam int CPB = 4;
  localparam int CPB_S = 434;
  logic clk = 1'b0, rst = 1'b0;
  logic [7:0] din = '0, din_s = '0;
  logic send = 1'b0, send_s = 1'b0;
  logic txd, busy, done, txd_s, busy_s, done_s;
  int n_checks = 0, n_fail = 0;
  typedef struct {
    logic [7:0]  din;
    logic [31:0] chars;
  } vec_t;
  vec_t vecs[4];

  uart_hex_byte_sender #(.CLKS_PER_BIT(CPB)) u_fast (
    .clk(clk), .rst(rst), .data_in(din), .send(send),
    .uart_txd(txd), .busy(busy), .done(done)
  );
  uart_hex_byte_sender u_slow (
    .clk(clk), .rst(rst), .data_in(din_s), .send(send_s),
    .uart_txd(txd_s), .busy(busy_s), .done(done_s)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one full sequence on the fast DUT, checking every cycle against the expected waveform.
  task automatic run_seq(input string name, input logic [7:0] d, input logic [31:0] exp,
                         input bit pre_sent, input int inj_at, input logic [7:0] inj_d,
                         input bit chain, input logic [7:0] chain_d);
    logic [7:0] got[4];
    logic [7:0] ch;
    logic e;
    int j, p, wave_bad, busy_low, done_hi;
    wave_bad = 0; busy_low = 0; done_hi = 0;
    if (!pre_sent) begin
      @(negedge clk);
      din = d;
      send = 1'b1;
    end
    @(posedge clk);
    for (int m = 0; m < 40 * CPB; m++) begin
      @(negedge clk);
      if (m == 0) send = 1'b0;
      j = m / CPB;
      p = j % 10;
      ch = exp[31 - 8 * (j / 10) -: 8];
      e = p == 0 ? 1'b0 : p == 9 ? 1'b1 : ch[p - 1];
      if (txd !== e) wave_bad++;
      if (m % CPB == CPB / 2 && p >= 1 && p <= 8) got[j / 10][p - 1] = txd;
      if (busy !== 1'b1) busy_low++;
      if (done !== 1'b0) done_hi++;
      if (m == inj_at) begin
        send = 1'b1;
        din = inj_d;
      end else if (m == inj_at + 1) send = 1'b0;
    end
    @(negedge clk);
    chk({name, "_end_busy"}, busy, 0);
    chk({name, "_end_done"}, done, 1);
    chk({name, "_end_txd"}, txd, 1);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s_char%0d", name, k), got[k], exp[31 - 8 * k -: 8]);
    chk({name, "_wave_bad_cycles"}, wave_bad, 0);
    chk({name, "_busy_low_cycles"}, busy_low, 0);
    chk({name, "_done_early_cycles"}, done_hi, 0);
    if (chain) begin
      din = chain_d;
      send = 1'b1;
    end else begin
      @(negedge clk);
      chk({name, "_post_done"}, done, 0);
      chk({name, "_post_busy"}, busy, 0);
    end
  endtask

  initial begin
    logic [31:0] exp_s;
    logic [7:0] ch;
    logic e;
    int bad, done_seen;
    vecs[0] = '{8'h3C, 32'h33430D0A};
    vecs[1] = '{8'h00, 32'h30300D0A};
    vecs[2] = '{8'h9A, 32'h39410D0A};
    vecs[3] = '{8'hFF, 32'h46460D0A};
    repeat (3) @(negedge clk);
    chk("reset_txd", txd, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_slow_txd", txd_s, 1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 4; i++)
      run_seq($sformatf("vec%0d", i), vecs[i].din, vecs[i].chars, 1'b0, -1, 8'h00, 1'b0, 8'h00);
    // Mid-sequence request with new data must be ignored and not change the latched byte.
    run_seq("ignored", 8'h12, 32'h31320D0A, 1'b0, 50, 8'hEE, 1'b0, 8'h00);
    // Request during the done cycle starts the next sequence on the following edge.
    run_seq("b2b_first", 8'h9A, 32'h39410D0A, 1'b0, -1, 8'h00, 1'b1, 8'hA5);
    run_seq("b2b_second", 8'hA5, 32'h41350D0A, 1'b1, -1, 8'h00, 1'b0, 8'h00);
    // Reset during a zero data bit of character 1 (0x43, bit 2).
    @(negedge clk);
    din = 8'h3C;
    send = 1'b1;
    @(posedge clk);
    @(negedge clk);
    send = 1'b0;
    repeat (53) @(negedge clk);
    chk("pre_rst_txd", txd, 0);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_txd", txd, 1);
    chk("async_rst_busy", busy, 0);
    done_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) done_seen++;
    end
    rst = 1'b1;
    repeat (2 * CPB) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0 || txd !== 1'b1) done_seen++;
    end
    chk("rst_no_done_idle", done_seen, 0);
    run_seq("after_rst", 8'h7E, 32'h37450D0A, 1'b0, -1, 8'h00, 1'b0, 8'h00);
    // Full-rate bit timing on the default-parameter instance.
    exp_s = 32'h35410D0A;
    @(negedge clk);
    din_s = 8'h5A;
    send_s = 1'b1;
    @(posedge clk);
    for (int j = 0; j < 40; j++) begin
      bad = 0;
      ch = exp_s[31 - 8 * (j / 10) -: 8];
      e = j % 10 == 0 ? 1'b0 : j % 10 == 9 ? 1'b1 : ch[j % 10 - 1];
      for (int c = 0; c < CPB_S; c++) begin
        @(negedge clk);
        if (j == 0 && c == 0) send_s = 1'b0;
        if (txd_s !== e || busy_s !== 1'b1 || done_s !== 1'b0) bad++;
      end
      chk($sformatf("slow_bit%0d_bad_cycles", j), bad, 0);
    end
    @(negedge clk);
    chk("slow_end_done", done_s, 1);
    chk("slow_end_busy", busy_s, 0);
    chk("slow_end_txd", txd_s, 1);
    @(negedge clk);
    chk("slow_post_done", done_s, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_hex_byte_sender.md
# uart_hex_byte_sender

Transmit-side companion to the UART receive/SSD display path. On a single-cycle request it captures an 8-bit value and sends it over `uart_txd` as four 8N1 characters: upper-nibble ASCII hex digit, lower-nibble ASCII hex digit, CR, LF. It includes its own baud-rate serializer and character sequencer, so a terminal shows the byte as a hex line. It sits beside the receiver at the board top level and drives the board TX pin directly.

## Interface
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200 baud). Must be ≥ 2.
- `clk`  input  1  system clock, 50 MHz.
- `rst`  input  1  asynchronous, active-low reset (0 = reset).
- `data_in`  input  8  byte to report; sampled only when a request is accepted.
- `send`  input  1  request strobe, active-high; accepted on any rising `clk` edge where `busy` = 0.
- `uart_txd`  output  1  serial output, idle high.
- `busy`  output  1  high from the cycle after acceptance until the last stop bit completes.
- `done`  output  1  one-cycle pulse when a 4-character sequence completes.

## Operation
- Reset values: `uart_txd` = 1, `busy` = 0, `done` = 0. The FSM is in IDLE, and all counters and the character index are 0.
- FSM states and transitions:
  - IDLE: on an accepted `send`, go to START.
  - START: send 1 bit of 0, then go to DATA.
  - DATA: send 8 bits, LSB first, then go to STOP.
  - STOP: send 1 bit of 1. If the character index is less than 3, advance the index and go to START; otherwise return to IDLE.
- Acceptance latches `data_in` into an internal register. Later changes on `data_in` do not affect the sequence in flight.
- Character sequence, by index:
  - 0: hex(`data_in[7:4]`)
  - 1: hex(`data_in[3:0]`)
  - 2: 0x0D (CR)
  - 3: 0x0A (LF)
- Hex mapping uses uppercase digits:
  - nibble 0–9 → 0x30 + nibble
  - nibble 10–15 → 0x37 + nibble (0x41–0x46)
- Characters go out back-to-back. The next start bit follows immediately after the previous stop bit, with no idle gap.
- The baud counter counts 0 to `CLKS_PER_BIT`−1 and is $clog2(`CLKS_PER_BIT`) bits wide. The bit index counts 0–7 (3 bits). The character index counts 0–3 (2 bits).
- `send` while `busy` = 1 is ignored. It is not queued.
- Reset asserted mid-operation:
  - `uart_txd` returns to 1 immediately (asynchronously).
  - The sequence is abandoned and `done` does not pulse.
  - After reset releases, the block is in IDLE.

## Timing
- Acceptance edge is E0. From E0, `busy` = 1 and `uart_txd` = 0 (start bit of character 0).
- Each bit is held for exactly `CLKS_PER_BIT` cycles. A frame lasts 10 × `CLKS_PER_BIT` cycles, and a full sequence lasts 40 × `CLKS_PER_BIT` cycles.
- At edge E0 + 40 × `CLKS_PER_BIT`:
  - `busy` → 0 and `done` → 1 for exactly one cycle.
  - `uart_txd` stays 1.
- A `send` sampled at the end of that `done` cycle is accepted. This gives a minimum of one idle-high cycle between sequences.
- `done` and `busy` are never high in the same cycle.
- `uart_txd` is driven from a register, so it is glitch-free.

## Test plan
- Basic byte, `CLKS_PER_BIT` = 4: `data_in` = 0x3C, pulse `send` → decoded bytes 0x33, 0x43, 0x0D, 0x0A. `busy` stays high for exactly 160 cycles, then `done` pulses once.
- Nibble boundaries: 0x00 → 0x30 0x30 0x0D 0x0A. 0x9A → 0x39 0x41 0x0D 0x0A. 0xFF → 0x46 0x46 0x0D 0x0A.
- Bit timing, default `CLKS_PER_BIT` = 434: measure every bit of 0x5A → each bit is 434 cycles, start bit = 0, stop bit = 1, LSB first, and there is no gap between characters.
- Ignored requests and latch: with 0x12 in flight, pulse `send` mid-sequence and change `data_in` to 0xEE → only 0x31 0x32 0x0D 0x0A is sent, followed by a single `done`.
- Back-to-back: assert `send` with `data_in` = 0xA5 during the `done` cycle → the second sequence's start bit begins the next cycle and decodes to 0x41 0x35 0x0D 0x0A.
- Reset mid-frame: assert `rst` = 0 during the DATA state of character 1 → `uart_txd` = 1 and `busy` = 0 with no clock edge needed, and no `done` pulse. A fresh `send` of 0x7E after release sends 0x37 0x45 0x0D 0x0A.
